// File: rtl/random_delay_pkg.sv
// Shared types and constants for the random delay block.
package random_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } delay_state_t;

  // Smallest delay ever loaded; a computed delay of zero is raised to this.
  localparam int unsigned MIN_DELAY = 1;

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter used to count delay units.
// clear has priority over load, and load has priority over dec.
// Decrementing stops at zero.
module delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Counter register: clear, load or decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/random_delay.sv
// Random delay timer. On trigger it captures lfsr_in + OFFSET as a delay and
// counts that many tick pulses. It then pulses time_out for one cycle.
// The LFSR is enabled only while idle.
// Optional feature: define RANDOM_DELAY_ABORT_EN to add an abort input that
// cancels a delay in progress without producing time_out.
module random_delay
  import random_delay_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int OFFSET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             tick,
`ifdef RANDOM_DELAY_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] lfsr_in,
  output logic             lfsr_en,
  output logic             busy,
  output logic             time_out,
  output logic [WIDTH:0]   delay_val
);

  localparam logic [WIDTH:0] OFFSET_EXT = (WIDTH+1)'(OFFSET);
  localparam logic [WIDTH:0] ONE        = (WIDTH+1)'(1);

  // The delay is one bit wider than the LFSR word, so the sum cannot overflow.
  // A zero result is raised to the minimum delay.
  function automatic logic [WIDTH:0] clamp_delay(input logic [WIDTH-1:0] word);
    logic [WIDTH:0] sum;
    sum = {1'b0, word} + OFFSET_EXT;
    if (sum == '0) begin
      sum = (WIDTH+1)'(MIN_DELAY);
    end
    return sum;
  endfunction

  delay_state_t   state;
  logic [WIDTH:0] count;
  logic           ctr_zero;
  logic           abort_hit;
  logic           ctr_load;
  logic           ctr_dec;
  logic           ctr_clear;
  logic           last_tick;
  logic [WIDTH:0] delay_next;

`ifdef RANDOM_DELAY_ABORT_EN
  assign abort_hit = (state == COUNT) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign delay_next = clamp_delay(lfsr_in);
  assign ctr_load   = (state == IDLE) && trigger;
  assign ctr_clear  = abort_hit;
  // Abort takes priority over a tick in the same cycle.
  assign ctr_dec    = (state == COUNT) && tick && !abort_hit;
  assign last_tick  = ctr_dec && (count == ONE);

  delay_counter #(
    .WIDTH (WIDTH + 1)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .clear    (ctr_clear),
    .load_val (delay_next),
    .count    (count),
    .zero     (ctr_zero)
  );

  // Control FSM. The outputs are registered alongside the state, so they are a
  // pure function of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      delay_val <= '0;
      time_out  <= 1'b0;
      busy      <= 1'b0;
      lfsr_en   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= COUNT;
            delay_val <= delay_next;
            busy      <= 1'b1;
            lfsr_en   <= 1'b0;
          end
        end
        COUNT: begin
          if (abort_hit) begin
            state   <= IDLE;
            busy    <= 1'b0;
            lfsr_en <= 1'b1;
          // A zero count here is unreachable; it is only a safety exit.
          end else if (last_tick || ctr_zero) begin
            state    <= DONE;
            time_out <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          time_out <= 1'b0;
          busy     <= 1'b0;
          lfsr_en  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          time_out <= 1'b0;
          busy     <= 1'b0;
          lfsr_en  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_delay.sv
// Scoreboard bench for random_delay. dut_a uses OFFSET=1 and dut_b uses OFFSET=0.
// Build with RANDOM_DELAY_ABORT_EN defined to include the abort scenario.
module tb_random_delay;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic       tick = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] lfsr_in = 7'h00;

  logic       en_a, busy_a, to_a;
  logic [7:0] dv_a;
  logic       en_b, busy_b, to_b;
  logic [7:0] dv_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [7:0] dv;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  random_delay #(.WIDTH(7), .OFFSET(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig_a),
    .tick      (tick),
`ifdef RANDOM_DELAY_ABORT_EN
    .abort     (abort),
`endif
    .lfsr_in   (lfsr_in),
    .lfsr_en   (en_a),
    .busy      (busy_a),
    .time_out  (to_a),
    .delay_val (dv_a)
  );

  random_delay #(.WIDTH(7), .OFFSET(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig_b),
    .tick      (tick),
`ifdef RANDOM_DELAY_ABORT_EN
    .abort     (1'b0),
`endif
    .lfsr_in   (lfsr_in),
    .lfsr_en   (en_b),
    .busy      (busy_b),
    .time_out  (to_b),
    .delay_val (dv_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every time_out pulse must match the oldest outstanding expectation.
  task automatic pop_check(input int id, input logic [7:0] dv);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_time_out dut %0d at cycle %0d: got pulse, expected none", id, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("time_out_dut", id, e.id);
      chk("time_out_delay_val", int'(dv), int'(e.dv));
      chk("time_out_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (to_a) pop_check(0, dv_a);
    if (to_b) pop_check(1, dv_b);
  end

  task automatic check_idle(input string tag);
    chk({tag, "_lfsr_en"}, int'(en_a), 1);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_time_out"}, int'(to_a), 0);
  endtask

  task automatic check_active(input int sel, input logic [7:0] dv);
    if (sel == 0) begin
      chk("count_busy", int'(busy_a), 1);
      chk("count_lfsr_en", int'(en_a), 0);
      chk("count_delay_val", int'(dv_a), int'(dv));
    end else begin
      chk("count_busy", int'(busy_b), 1);
      chk("count_lfsr_en", int'(en_b), 0);
      chk("count_delay_val", int'(dv_b), int'(dv));
    end
  endtask

  // The trigger is driven at cycle c and sampled at edge c+1. Tick k is driven
  // at cycle c+k. The last tick is sampled at edge c+dv*period+1, so time_out
  // is seen in that cycle.
  task automatic run_delay(input int sel, input logic [6:0] word, input logic [7:0] dv,
                           input int period, input bit hold_trig);
    int c;
    int n;
    exp_t e;
    @(posedge clk); #1;
    lfsr_in = word;
    if (sel == 0) trig_a = 1'b1; else trig_b = 1'b1;
    c = cyc;
    n = int'(dv) * period;
    e.id = sel; e.dv = dv; e.cyc = c + n + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    lfsr_in = ~word;
    for (int k = 1; k <= n; k++) begin
      check_active(sel, dv);
      tick = ((k % period) == 0);
      if (!(hold_trig && k < n)) begin
        trig_a = 1'b0;
        trig_b = 1'b0;
      end
      @(posedge clk); #1;
    end
    tick = 1'b0;
    trig_a = 1'b0;
    trig_b = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    check_idle("in_reset");
    chk("in_reset_delay_val", int'(dv_a), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
      chk("idle_delay_val", int'(dv_a), 0);
    end

    // Basic: 5+1 = 6 ticks, one tick every 4th clock
    run_delay(0, 7'h05, 8'd6, 4, 1'b0);
    check_idle("after_basic");

    // Zero clamp: OFFSET 0, word 0 -> 1; tick held high
    run_delay(1, 7'h00, 8'd1, 1, 1'b0);
    // OFFSET 0, word 0x10 -> 16, tick every 2nd clock
    run_delay(1, 7'h10, 8'd16, 2, 1'b0);

    // Max value: 0x7F+1 = 0x80, with trigger held high during the count
    run_delay(0, 7'h7F, 8'h80, 1, 1'b1);

    // Reset mid-count: delay 10, reset after 4 ticks
    @(posedge clk); #1;
    lfsr_in = 7'h09; trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    chk("pre_reset_delay_val", int'(dv_a), 10);
    tick = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tick = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_busy", int'(busy_a), 0);
    chk("midreset_delay_val", int'(dv_a), 0);
    chk("midreset_time_out", int'(to_a), 0);
    chk("midreset_lfsr_en", int'(en_a), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    run_delay(0, 7'h2A, 8'd43, 2, 1'b0);

`ifdef RANDOM_DELAY_ABORT_EN
    // Abort: delay 8, abort together with the 3rd tick
    @(posedge clk); #1;
    lfsr_in = 7'h07; trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tick = 1'b0;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_lfsr_en", int'(en_a), 1);
    chk("abort_delay_val", int'(dv_a), 8);
    chk("abort_time_out", int'(to_a), 0);
    repeat (12) @(posedge clk);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/random_delay.md
Name: random_delay

Overview:
- Downstream consumer of the 7-bit LFSR in the FSM lab datapath.
- On `trigger`, captures the current LFSR word plus a fixed offset as a delay, counts that many `tick` pulses (from the clock-tick divider), then pulses `time_out` for one cycle. This drives the "lights out after random delay" step.
- Drives `lfsr_en` so the LFSR free-runs while idle and freezes while a delay is in progress.

Parameters:
- WIDTH, 7, LFSR word width.
- OFFSET, 1, constant added to the captured LFSR word; range 0..(2^WIDTH)-1.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- trigger  input  1  start request, sampled each clk.
- tick  input  1  one-cycle enable pulse from the tick divider; one tick equals one delay unit.
- lfsr_in  input  WIDTH  current LFSR output word.
- lfsr_en  output  1  enable to the LFSR; high only in IDLE.
- busy  output  1  high in COUNT and DONE.
- time_out  output  1  one-cycle pulse when the delay expires.
- delay_val  output  WIDTH+1  captured delay, held until the next capture.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, delay_val=0, time_out=0, busy=0, lfsr_en=1 once the state is IDLE.
- Arithmetic: the delay is `lfsr_in + OFFSET`, zero-extended to WIDTH+1 bits, so it never overflows.
  - A computed delay of 0 (only possible with OFFSET=0 and lfsr_in=0) is forced to 1.
- States: IDLE, COUNT, DONE. State is encoded as an enum from the package.
- IDLE:
  - lfsr_en=1, busy=0.
  - On trigger=1: count and delay_val load the delay; next state COUNT.
  - `tick` is ignored in IDLE, including in the trigger cycle.
- COUNT:
  - lfsr_en=0, busy=1.
  - On tick=1 with count>1: count decrements.
  - On tick=1 with count==1: count goes to 0; next state DONE.
  - No tick: count holds.
  - trigger is ignored (no retrigger).
- DONE:
  - time_out=1 for exactly this one cycle; busy=1, lfsr_en=0.
  - Next state is unconditionally IDLE; trigger in this cycle is ignored.
- Latency:
  - time_out asserts in the cycle after the clk edge that samples the delay-th tick in COUNT.
  - The minimum trigger-to-time_out gap is 2 clk cycles (delay=1, tick present in the first COUNT cycle).
- Outputs:
  - time_out, busy and lfsr_en are decoded from state only (Moore); no combinational path from the inputs.
  - delay_val is registered.
- Reset mid-COUNT: immediate return to IDLE with no time_out; delay_val clears to 0.
- Back-to-back: trigger held high continuously restarts on the first IDLE cycle after DONE, using the LFSR value present then.

Optional Feature:
- Macro: RANDOM_DELAY_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in COUNT forces next state IDLE with count=0 and no time_out; delay_val holds.
  - abort has priority over tick in the same cycle.
  - abort in IDLE or DONE has no effect.
- Undefined: the port is absent and COUNT exits only via the delay-th tick or reset.

Decomposition:
- Package `random_delay_pkg`:
  - state enum `delay_state_t` {IDLE, COUNT, DONE}.
  - localparam for the forced-minimum delay value (1).
- Sub-module: `delay_counter` (loadable down-counter with `load`, `dec` and `zero` flag, width WIDTH+1) is natural; the FSM remains in `random_delay`.
- No other sub-modules.

Test Plan:
- Reset then idle:
  - Stimulus: rst low 3 cycles, release, no trigger for 10 cycles.
  - Required: lfsr_en=1 throughout, busy=0, time_out=0, delay_val=0.
- Basic delay:
  - Stimulus: lfsr_in=7'h05, OFFSET=1, trigger pulse, then tick every 4th clk.
  - Required: delay_val=6; busy from the next cycle; time_out exactly once, one cycle after the 6th tick; lfsr_en low throughout.
- Minimum and zero clamp:
  - Stimulus: OFFSET=0, lfsr_in=0, trigger, tick constant high.
  - Required: delay_val=1; time_out 2 cycles after trigger.
- Max value:
  - Stimulus: lfsr_in=7'h7F, OFFSET=1.
  - Required: delay_val=8'h80; time_out after 128 ticks; retriggers in COUNT ignored.
- Reset mid-operation:
  - Stimulus: trigger with delay 10, assert rst after 4 ticks.
  - Required: immediate busy=0, delay_val=0, no time_out; a new trigger after release works normally.
- Abort (RANDOM_DELAY_ABORT_EN defined):
  - Stimulus: delay 8, abort together with the 3rd tick.
  - Required: return to IDLE the next cycle, no time_out, delay_val still 8, lfsr_en=1.
